// File: rtl/kyber_pkg.sv
// Shared types and constants for the Kyber byte/bit stream helpers.
package kyber_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    B2B_IDLE,
    B2B_COLLECT,
    B2B_FINISH
  } b2b_state_t;

endpackage

// File: rtl/bits_to_bytes_stream_bit_pack_acc.sv
// LSB-first bit accumulator: merges IN_W-bit beats into one byte and flags
// the beat that completes it.
module bit_pack_acc
  import kyber_pkg::*;
#(
  parameter int IN_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              take,
  input  logic [IN_W-1:0]   in_bits,
  output logic [BYTE_W-1:0] byte_val,
  output logic              complete
);

  localparam int CNT_W = $clog2(BYTE_W);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BYTE_W - IN_W);

  logic [BYTE_W-1:0] acc;
  logic [CNT_W-1:0]  bit_cnt;

  // Bits above bit_cnt are always zero, so OR-ing the shifted beat in
  // yields the byte including the current beat.
  always_comb begin
    byte_val = acc | (BYTE_W'(in_bits) << bit_cnt);
    complete = take && (bit_cnt == LAST_POS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      acc     <= complete ? '0 : byte_val;
      bit_cnt <= bit_cnt + CNT_W'(IN_W);
    end
  end

endmodule

// File: rtl/bits_to_bytes_stream.sv
// Bit-stream to byte-stream packer (Kyber BitsToBytes ordering) with
// valid/ready on both sides. Optional abort input: BITS_TO_BYTES_ABORT_EN.
module bits_to_bytes_stream
  import kyber_pkg::*;
#(
  parameter int BYTE_COUNT = 256,
  parameter int IN_W       = 1,
  parameter int LEN_W      = $clog2(BYTE_COUNT) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [IN_W-1:0]   in_bits,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef BITS_TO_BYTES_ABORT_EN
  ,
  input  logic              abort
`endif
);

  if (!(IN_W == 1 || IN_W == 2 || IN_W == 4 || IN_W == 8)) begin : g_bad_in_w
    $error("bits_to_bytes_stream: IN_W must be 1, 2, 4 or 8");
  end

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BYTE_COUNT);

  b2b_state_t        state;
  logic [LEN_W-1:0]  bytes_left;
  logic              take;
  logic              complete;
  logic              start_ok;
  logic              clr;
  logic [BYTE_W-1:0] byte_val;

  always_comb begin
    in_ready = (state == B2B_COLLECT) && (bytes_left != '0) && (!out_valid || out_ready);
    take     = in_valid && in_ready;
    start_ok = (state == B2B_IDLE) && start;
    busy     = (state == B2B_COLLECT);
  end

`ifdef BITS_TO_BYTES_ABORT_EN
  assign clr = start_ok || abort;
`else
  assign clr = start_ok;
`endif

  bit_pack_acc #(.IN_W(IN_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .take     (take),
    .in_bits  (in_bits),
    .byte_val (byte_val),
    .complete (complete)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= B2B_IDLE;
      bytes_left <= '0;
      out_byte   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end
`ifdef BITS_TO_BYTES_ABORT_EN
    else if (abort) begin
      state      <= B2B_IDLE;
      bytes_left <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      // A completing beat only gets in when the output slot frees this cycle.
      if (complete) begin
        out_byte   <= byte_val;
        out_valid  <= 1'b1;
        out_last   <= (bytes_left == LEN_W'(1));
        bytes_left <= bytes_left - LEN_W'(1);
      end
      case (state)
        B2B_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= B2B_FINISH;
              done  <= 1'b1;
            end else begin
              state      <= B2B_COLLECT;
              bytes_left <= (len > MAX_LEN) ? MAX_LEN : len;
            end
          end
        end
        B2B_COLLECT: begin
          if (out_valid && out_ready && out_last) begin
            state <= B2B_FINISH;
            done  <= 1'b1;
          end
        end
        B2B_FINISH: state <= B2B_IDLE;
        default:    state <= B2B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Directed bench for bits_to_bytes_stream: three instances (IN_W 1/4/8)
// checked every cycle against a bit-queue model of the byte stream.
module tb_bits_to_bytes_stream;

  localparam int NB = 3;

  typedef struct {
    logic [7:0] b;
    logic       last;
    int         cyc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] start, in_valid, in_ready, out_valid, out_last, busy, done;
  logic [8:0]    len;
  logic [7:0]    in_data;
  logic          out_ready;
  logic [7:0]    ob [NB];
`ifdef BITS_TO_BYTES_ABORT_EN
  logic          abort;
`endif

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  ent_t       expq   [NB][$];
  logic       bq     [NB][$];
  logic [7:0] modlog [NB][$];
  int         lenl[NB], bits_acc[NB], made[NB], exp_done[NB];
  bit         active[NB], hold[NB], seen_done[NB];
  logic [7:0] hb[NB];
  logic       hl[NB];

  always #5 clk = ~clk;

  bits_to_bytes_stream #(.BYTE_COUNT(256), .IN_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .len(len), .in_bits(in_data[0:0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_byte(ob[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
`ifdef BITS_TO_BYTES_ABORT_EN
    , .abort(abort)
`endif
  );

  bits_to_bytes_stream #(.BYTE_COUNT(256), .IN_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .len(len), .in_bits(in_data[3:0]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_byte(ob[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
`ifdef BITS_TO_BYTES_ABORT_EN
    , .abort(abort)
`endif
  );

  bits_to_bytes_stream #(.BYTE_COUNT(4), .IN_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .len(len[2:0]), .in_bits(in_data),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_byte(ob[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_last(out_last[2]), .busy(busy[2]), .done(done[2])
`ifdef BITS_TO_BYTES_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic int wof(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 8;
  endfunction

  function automatic int bcof(input int d);
    return (d == 2) ? 4 : 256;
  endfunction

  function automatic int lenof(input int d);
    return (d == 2) ? int'(len[2:0]) : int'(len);
  endfunction

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s (dut %0d-cycle %0d): got 0x%0h expected 0x%0h", nm, 0, cyc, act, exp);
    end
  endtask

  function automatic void clear_model();
    for (int d = 0; d < NB; d++) begin
      active[d]   = 1'b0;
      hold[d]     = 1'b0;
      exp_done[d] = -1;
      bits_acc[d] = 0;
      made[d]     = 0;
      bq[d].delete();
      expq[d].delete();
    end
  endfunction

  // Model: bits appended in arrival order; every 8 bits form the next byte.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < NB; d++) begin
      bit   idle_now, exp_ir;
      ent_t e;
      idle_now = !active[d] && (exp_done[d] != cyc);
      if (done[d] !== 1'b0 || exp_done[d] == cyc) begin
        chk("done_pulse", done[d] === 1'b1 && exp_done[d] == cyc, done[d], exp_done[d] == cyc);
        if (done[d] === 1'b1) seen_done[d] = 1'b1;
      end
      chk("busy", busy[d] === active[d], busy[d], active[d]);
      exp_ir = active[d] && (bits_acc[d] < 8 * lenl[d]) && !(out_valid[d] === 1'b1 && !out_ready);
      chk("in_ready", in_ready[d] === exp_ir, in_ready[d], exp_ir);
      if (hold[d])
        chk("out_hold", out_valid[d] === 1'b1 && ob[d] === hb[d] && out_last[d] === hl[d],
            {out_valid[d], out_last[d], ob[d]}, {1'b1, hl[d], hb[d]});
      if (out_valid[d] !== 1'b0) begin
        if (expq[d].size() == 0) chk("spurious_out_valid", 1'b0, out_valid[d], 0);
        else begin
          chk("out_byte", ob[d] === expq[d][0].b, ob[d], expq[d][0].b);
          chk("out_last", out_last[d] === expq[d][0].last, out_last[d], expq[d][0].last);
          if (!hold[d]) chk("out_latency", cyc == expq[d][0].cyc, cyc, expq[d][0].cyc);
          if (out_ready) begin
            if (expq[d][0].last) begin
              active[d]   = 1'b0;
              exp_done[d] = cyc + 1;
            end
            void'(expq[d].pop_front());
          end
        end
      end else if (expq[d].size() > 0 && expq[d][0].cyc <= cyc) begin
        chk("out_valid_missing", 1'b0, 0, 1);
      end
      hold[d] = (out_valid[d] === 1'b1) && !out_ready;
      hb[d]   = ob[d];
      hl[d]   = out_last[d];
      if (in_valid[d] && in_ready[d] === 1'b1) begin
        for (int b = 0; b < wof(d); b++) bq[d].push_back(in_data[b]);
        bits_acc[d] += wof(d);
        while (bq[d].size() >= 8) begin
          e.b = '0;
          for (int b = 0; b < 8; b++) e.b[b] = bq[d].pop_front();
          made[d]++;
          e.last = (made[d] == lenl[d]);
          e.cyc  = cyc + 1;
          expq[d].push_back(e);
          modlog[d].push_back(e.b);
        end
      end
      if (start[d] && idle_now) begin
        lenl[d]     = (lenof(d) > bcof(d)) ? bcof(d) : lenof(d);
        made[d]     = 0;
        bits_acc[d] = 0;
        bq[d].delete();
        if (lenl[d] == 0) exp_done[d] = cyc + 1;
        else active[d] = 1'b1;
      end
    end
    if (!rst_n) clear_model();
`ifdef BITS_TO_BYTES_ABORT_EN
    if (abort) clear_model();
`endif
  end

  task automatic beat(input int d, input logic [7:0] data);
    bit acc;
    int t;
    in_valid[d] = 1'b1;
    in_data     = data;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready[d];
      @(posedge clk);
      #1;
      t++;
    end
    chk("beat_accept", acc, acc, 1);
  endtask

  task automatic run_msg(input int d, input int ln, input logic [7:0] chunks[$], input int extra);
    int t;
    modlog[d].delete();
    seen_done[d] = 1'b0;
    len      = 9'(ln);
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    foreach (chunks[i]) beat(d, chunks[i]);
    for (int e = 0; e < extra; e++) begin
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    t = 0;
    while (!seen_done[d] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", seen_done[d], seen_done[d], 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int d, input logic [7:0] exp[$]);
    chk("model_count", modlog[d].size() == exp.size(), modlog[d].size(), exp.size());
    foreach (exp[i])
      if (i < modlog[d].size()) chk("model_byte", modlog[d][i] == exp[i], modlog[d][i], exp[i]);
  endtask

  initial begin
    logic [7:0] none[$];
    int t;
    rst_n     = 1'b0;
    start     = '0;
    in_valid  = '0;
    len       = '0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef BITS_TO_BYTES_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NB; d++)
      chk("reset_outputs", {in_ready[d], out_valid[d], out_last[d], busy[d], done[d], ob[d]} == 13'd0,
          {in_ready[d], out_valid[d], out_last[d], busy[d], done[d], ob[d]}, 0);
    @(posedge clk);
    #1;

    // 1: single byte, 1 bit per beat
    run_msg(0, 1, '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1}, 0);
    pin(0, '{8'hA5});

    // 2: nibbles, back-to-back, with two surplus beats offered at the end
    run_msg(1, 3, '{8'h5, 8'hA, 8'h3, 8'hC, 8'hF, 8'h0}, 2);
    pin(1, '{8'hA5, 8'hC3, 8'h0F});

    // 3: whole bytes with the first output stalled for 5 cycles
    out_ready = 1'b0;
    fork
      run_msg(2, 4, '{8'h11, 8'h22, 8'h33, 8'h44}, 0);
      begin
        t = 0;
        while (out_valid[2] !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("stall_reached", out_valid[2] === 1'b1, out_valid[2], 1);
        for (int k = 0; k < 5; k++) begin
          chk("stall_byte", ob[2] == 8'h11, ob[2], 8'h11);
          chk("stall_in_ready", in_ready[2] == 1'b0, in_ready[2], 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    pin(2, '{8'h11, 8'h22, 8'h33, 8'h44});

    // len above BYTE_COUNT is clamped; further beats are refused
    run_msg(2, 6, '{8'h01, 8'h02, 8'h03, 8'h04}, 3);
    pin(2, '{8'h01, 8'h02, 8'h03, 8'h04});

    // 4: empty message
    run_msg(0, 0, none, 0);
    pin(0, none);

    // 5: reset mid-message, then a clean byte
    len      = 9'd1;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    beat(0, 8'd1);
    beat(0, 8'd0);
    beat(0, 8'd1);
    in_valid[0] = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_msg(0, 1, '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 0);
    pin(0, '{8'hFF});

`ifdef BITS_TO_BYTES_ABORT_EN
    // 6: abort while a byte is pending
    out_ready = 1'b0;
    len       = 9'd2;
    start[1]  = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    beat(1, 8'h5);
    beat(1, 8'hA);
    in_valid[1] = 1'b0;
    chk("abort_pending", out_valid[1] == 1'b1, out_valid[1], 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_cleared", {out_valid[1], busy[1], done[1]} == 3'd0, {out_valid[1], busy[1], done[1]}, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    run_msg(1, 2, '{8'h3, 8'hC, 8'hF, 8'h0}, 0);
    pin(1, '{8'hC3, 8'h0F});
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
